// File: rtl/bcd_counter_7seg_mux.sv
// Multi-digit BCD up/down counter with prescaler, clear/load, and a time-multiplexed 7-segment driver.
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module bcd_counter_7seg_mux #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  logic [4*DIGITS-1:0] count_q, count_d, step_val, sat_val;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                tick, carry;
  logic [3:0]          nib, shown_nib;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  assign tick = run && (presc_q == PW'(PRESCALE - 1));

  // Ripple carry/borrow across digits; carry out of the top digit is the rollover.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    nib      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          step_val[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
          carry              = (nib == 4'd9);
        end else begin
          step_val[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
          carry              = (nib == 4'd0);
        end
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      sat_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = sat_val;
      presc_d = '0;
    end else if (run) begin
      if (tick) begin
        count_d = step_val;
        wrap_d  = carry;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Scan is free-running; segments decode the pre-edge count at the post-edge digit index.
  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    shown_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_d[i] = (idx_d == IW'(i));
      if (idx_d == IW'(i)) shown_nib = count_q[4*i +: 4];
    end
    seg_d = decode(shown_nib);
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DIGITS; i++) begin
      if ((idx_d == IW'(i)) && ((count_q >> (4*i)) == '0)) seg_d = 7'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= DIGITS'(1);
      seg_q   <= 7'h3F;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign segments  = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Bench for bcd_counter_7seg_mux: directed scenarios plus randomized traffic vs an integer-based reference model.
module tb_bcd_counter_7seg_mux;

  localparam int D  = 2;
  localparam int P  = 3;
  localparam int SD = 4;
  localparam int MAXV = 99;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run, up, clear, load;
  logic [4*D-1:0]  load_val;
  logic [4*D-1:0]  count;
  logic            wrap;
  logic [6:0]      segments;
  logic [D-1:0]    digit_sel;

  int nerr = 0;
  int nchk = 0;
  int nwrap;

  int   m_cnt, m_presc, m_scan, m_idx;
  logic m_wrap;
  logic [6:0] m_seg;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_counter_7seg_mux #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .segments(segments), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int sat_to_int(input logic [4*D-1:0] lv);
    int r = 0;
    for (int i = 0; i < D; i++) begin
      int n = int'(lv[4*i +: 4]);
      r += ((n > 9) ? 9 : n) * pow10(i);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_wrap = 1'b0; m_seg = 7'h3F;
  endtask

  task automatic model_step();
    int old = m_cnt;
    m_wrap = 1'b0;
    if (clear) begin
      m_cnt = 0; m_presc = 0;
    end else if (load) begin
      m_cnt = sat_to_int(load_val); m_presc = 0;
    end else if (run) begin
      if (m_presc == P - 1) begin
        m_presc = 0;
        if (up) begin
          m_wrap = (m_cnt == MAXV);
          m_cnt  = (m_cnt + 1) % (MAXV + 1);
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAXV) % (MAXV + 1);
        end
      end else begin
        m_presc++;
      end
    end
    if (m_scan == SD - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % D;
    end else begin
      m_scan++;
    end
    m_seg = seg_tab[(old / pow10(m_idx)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (m_idx > 0 && (old / pow10(m_idx)) == 0) m_seg = 7'h00;
`endif
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(to_bcd(m_cnt)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("segments", 32'(segments), 32'(m_seg));
    check("digit_sel", 32'(digit_sel), 32'(1 << m_idx));
  endtask

  // Inputs are set at the negedge before calling; model advances with the DUT edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (wrap) nwrap++;
    check_all();
  endtask

  task automatic set_in(input logic r, input logic u, input logic c, input logic l, input logic [4*D-1:0] lv);
    run = r; up = u; clear = c; load = l; load_val = lv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count", 32'(count), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_seg", 32'(segments), 32'h3F);
    check("rst_sel", 32'(digit_sel), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // 100 ticks up from 00: back at 00 with exactly one wrap pulse
    nwrap = 0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (100 * P) cyc();
    check("up100_count", 32'(count), 32'h00);
    check("up100_wraps", 32'(nwrap), 32'd1);

    // down from 00 rolls to 99 with wrap, then 98 without
    set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (P) cyc();
    check("down_roll_count", 32'(count), 32'h99);
    check("down_roll_wrap", 32'(wrap), 32'h1);
    repeat (P) cyc();
    check("down_next_count", 32'(count), 32'h98);
    check("down_next_wrap", 32'(wrap), 32'h0);

    // clear, 9 running cycles -> 03, then hold
    set_in(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (9) cyc();
    check("presc_count", 32'(count), 32'h03);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) cyc();
    check("hold_count", 32'(count), 32'h03);

    // load saturation, and clear overriding load
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'hA7);
    cyc();
    check("load_sat", 32'(count), 32'h97);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 8'hA7);
    cyc();
    check("clear_over_load", 32'(count), 32'h00);

    // scan pattern with a held value, then a value with a leading zero
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
    cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (4 * SD) cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (4 * SD) cyc();

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 3) != 0,
               ($urandom_range(0, 15) == 0) ? ~up : up,
               $urandom_range(0, 63) == 0,
               $urandom_range(0, 31) == 0,
               8'($urandom));
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
